// File: rtl/pipe_rr_arbiter_if.sv
// pipe_rr_arbiter_if: request, issue, result and response bundles around pipe_rr_arbiter
interface pipe_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32
);
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic pipe_valid_o;
  logic [DATA_W-1:0] pipe_data_o;
  logic pipe_ready_i;
  logic pipe_valid_i;
  logic [DATA_W-1:0] pipe_data_i;
  logic pipe_ready_o;
  logic [NUM_REQ-1:0] rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [NUM_REQ-1:0] rsp_ready_i;
  logic err_o;
  modport slave (
    input req_valid_i, req_data_i, pipe_ready_i, pipe_valid_i, pipe_data_i, rsp_ready_i,
    output req_ready_o, pipe_valid_o, pipe_data_o, pipe_ready_o, rsp_valid_o, rsp_data_o, err_o
  );
  modport master (
    output req_valid_i, req_data_i, pipe_ready_i, pipe_valid_i, pipe_data_i, rsp_ready_i,
    input req_ready_o, pipe_valid_o, pipe_data_o, pipe_ready_o, rsp_valid_o, rsp_data_o, err_o
  );
endinterface

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: round-robin issue into one shared in-order pipeline, results routed back by a tag FIFO
// Optional PIPE_ARB_ERR_CHK_EN: sticky err_o on spurious results or unstable pending payloads
module pipe_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter int MAX_OUTST = 4
) (
  input logic clk,
  input logic rst,
  pipe_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, winner, head;
  logic [IW-1:0] tags_q [MAX_OUTST];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic [DATA_W-1:0] data_q;
  logic [NUM_REQ-1:0] grant;
  logic found, can_accept, accept, empty, rsp_ok, pop;
  always_comb begin
    logic [IW-1:0] idx;
    idx = '0;
    winner = rr_q;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(rr_q) + i) % NUM_REQ);
      if (!found && bus.req_valid_i[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  // count_q already includes the transaction parked in the issue register
  assign can_accept = (state_q == IDLE || bus.pipe_ready_i) && count_q < CW'(MAX_OUTST);
  assign accept = !rst && can_accept && found;
  assign grant = accept ? NUM_REQ'(1) << winner : '0;
  assign empty = count_q == '0;
  assign head = tags_q[rd_q];
  assign rsp_ok = !empty && bus.rsp_ready_i[head];
  assign pop = bus.pipe_valid_i && rsp_ok;
  always_comb begin
    state_d = accept ? HOLD : bus.pipe_ready_i ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
      rr_q <= '0;
      count_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= bus.req_data_i[winner*DATA_W +: DATA_W];
        rr_q <= IW'((int'(winner) + 1) % NUM_REQ);
        tags_q[wr_q] <= winner;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(accept) - CW'(pop);
    end
  end
  assign bus.req_ready_o = grant;
  assign bus.pipe_valid_o = state_q == HOLD;
  assign bus.pipe_data_o = data_q;
  assign bus.pipe_ready_o = rsp_ok;
  assign bus.rsp_valid_o = (bus.pipe_valid_i && !empty) ? NUM_REQ'(1) << head : '0;
  assign bus.rsp_data_o = bus.pipe_data_i;
`ifdef PIPE_ARB_ERR_CHK_EN
  logic err_q, unstable;
  logic [NUM_REQ-1:0] wait_q;
  logic [NUM_REQ*DATA_W-1:0] held_q;
  // a requester left waiting last cycle must present the same payload this cycle
  always_comb begin
    unstable = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      unstable = unstable | (wait_q[k] && bus.req_valid_i[k] &&
                 bus.req_data_i[k*DATA_W +: DATA_W] != held_q[k*DATA_W +: DATA_W]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      wait_q <= '0;
      held_q <= '0;
    end else begin
      err_q <= err_q | unstable | (bus.pipe_valid_i && empty);
      wait_q <= bus.req_valid_i & ~grant;
      held_q <= bus.req_data_i;
    end
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// tb_pipe_rr_arbiter: directed scoreboard bench for pipe_rr_arbiter with a 3-cycle echo pipeline model
module tb_pipe_rr_arbiter;
  localparam int N = 4;
  localparam int W = 32;
`ifdef PIPE_ARB_ERR_CHK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  typedef struct {
    logic [W-1:0] d;
    int t;
  } pend_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] rdat [N];
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] rsp_ready = '1;
  logic pipe_ready = 1'b1;
  logic inj = 1'b0;
  logic [W-1:0] inj_data = '0;
  logic mvalid = 1'b0;
  logic [W-1:0] mdata = '0;
  logic mhold = 1'b0;
  int cyc_n = 0;
  pend_t pq[$];
  logic [35:0] sb[$];
  logic [35:0] mon_e;
  int exp_k = 0;
  int n_grant = 0;

  pipe_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  pipe_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_OUTST(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.req_valid_i = req_valid;
  assign bus.req_data_i = {rdat[3], rdat[2], rdat[1], rdat[0]};
  assign bus.pipe_ready_i = pipe_ready;
  assign bus.pipe_valid_i = inj | mvalid;
  assign bus.pipe_data_i = inj ? inj_data : mdata;
  assign bus.rsp_ready_i = rsp_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // shared pipeline: result is issued payload + 1, offered 3 cycles after issue, in order
  always @(posedge clk) begin
    if (rst) begin
      pq.delete();
      mvalid <= 1'b0;
    end else begin
      if (mvalid && bus.pipe_ready_o) void'(pq.pop_front());
      if (bus.pipe_valid_o && bus.pipe_ready_i) pq.push_back('{bus.pipe_data_o + 32'd1, cyc_n + 3});
      mvalid <= !mhold && pq.size() > 0 && pq[0].t <= cyc_n + 1;
      mdata <= pq.size() > 0 ? pq[0].d : '0;
    end
    cyc_n <= cyc_n + 1;
  end

  always @(negedge clk) begin
    #2;
    if (!rst && bus.rsp_valid_o != '0 && bus.pipe_ready_o) begin
      if (sb.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid_o), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_route", 64'(bus.rsp_valid_o), 64'(1) << mon_e[35:32]);
        chk("rsp_data", 64'(bus.rsp_data_o), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic run_grants(input int max_n, input int cycles);
    logic [N-1:0] g;
    n_grant = 0;
    for (int i = 0; i < cycles && n_grant < max_n; i++) begin
      #1;
      g = bus.req_ready_o;
      if (g != '0) begin
        chk("grant", 64'(g), 64'(1) << exp_k);
        sb.push_back({4'(exp_k), rdat[exp_k] + 32'd1});
        @(posedge clk); #1;
        rdat[exp_k] = rdat[exp_k] + 32'h0001_0000;
        exp_k = (exp_k + 1) % N;
        n_grant++;
        if (n_grant == max_n) req_valid = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(negedge clk); #3;
      w++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int w;
    for (int k = 0; k < N; k++) rdat[k] = 32'h100 + k;
    req_valid = '1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_pipe_valid", 64'(bus.pipe_valid_o), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk("rst_err", 64'(bus.err_o), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    run_grants(8, 40);
    chk("fair_count", 64'(n_grant), 64'd8);
    wait_drain("fair_drain");
    rdat[2] = 32'hA5A5_0001;
    pipe_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    chk("bp_grant", 64'(bus.req_ready_o), 64'h4);
    sb.push_back({4'd2, 32'hA5A5_0002});
    @(posedge clk); #1;
    rdat[2] = 32'hA5A5_0003;
    repeat (5) begin
      @(negedge clk); #1;
      chk("bp_valid", 64'(bus.pipe_valid_o), 64'd1);
      chk("bp_data", 64'(bus.pipe_data_o), 64'hA5A5_0001);
      chk("bp_no_grant", 64'(bus.req_ready_o), 64'd0);
    end
    @(negedge clk);
    pipe_ready = 1'b1;
    #1;
    chk("bp_issue_valid", 64'(bus.pipe_valid_o), 64'd1);
    chk("bp_next_grant", 64'(bus.req_ready_o), 64'h4);
    sb.push_back({4'd2, 32'hA5A5_0004});
    exp_k = 3;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk); #1;
    chk("bp_next_data", 64'(bus.pipe_data_o), 64'hA5A5_0003);
    wait_drain("bp_drain");
    mhold = 1'b1;
    req_valid = '1;
    run_grants(8, 10);
    chk("limit_count", 64'(n_grant), 64'd4);
    #1;
    chk("limit_block", 64'(bus.req_ready_o), 64'd0);
    mhold = 1'b0;
    @(negedge clk);
    mhold = 1'b1;
    #1;
    chk("limit_pop_cycle", 64'(bus.req_ready_o), 64'd0);
    chk("limit_pop_ready", 64'(bus.pipe_ready_o), 64'd1);
    @(negedge clk); #1;
    chk("limit_refill", 64'(bus.req_ready_o), 64'(1) << exp_k);
    sb.push_back({4'(exp_k), rdat[exp_k] + 32'd1});
    exp_k = (exp_k + 1) % N;
    @(posedge clk); #1;
    req_valid = '0;
    mhold = 1'b0;
    wait_drain("limit_drain");
    rsp_ready = 4'b1101;
    rdat[1] = 32'h0000_1111;
    req_valid = 4'b0010;
    #1;
    chk("stall_grant", 64'(bus.req_ready_o), 64'h2);
    sb.push_back({4'd1, 32'h0000_1112});
    @(posedge clk); #1;
    req_valid = '0;
    w = 0;
    while (bus.rsp_valid_o == '0 && w < 20) begin
      @(negedge clk); #1;
      w++;
    end
    chk("stall_arrive", 64'(w < 20), 64'd1);
    repeat (3) begin
      chk("stall_rsp_valid", 64'(bus.rsp_valid_o), 64'h2);
      chk("stall_pipe_ready", 64'(bus.pipe_ready_o), 64'd0);
      @(negedge clk); #1;
    end
    rsp_ready = '1;
    #1;
    chk("stall_release", 64'(bus.pipe_ready_o), 64'd1);
    wait_drain("stall_drain");
    inj_data = 32'hDEAD_BEEF;
    inj = 1'b1;
    #1;
    chk("spur_pipe_ready", 64'(bus.pipe_ready_o), 64'd0);
    chk("spur_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    @(negedge clk);
    inj = 1'b0;
    #1;
    chk("spur_err", 64'(bus.err_o), 64'(ERR_EN));
    @(negedge clk); #1;
    chk("spur_err_sticky", 64'(bus.err_o), 64'(ERR_EN));
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_err_clear", 64'(bus.err_o), 64'd0);
    chk("rst_pipe_idle", 64'(bus.pipe_valid_o), 64'd0);
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_rr_arbiter.md
Name: pipe_rr_arbiter

Overview:
- Shares one in-order valid/ready processing pipeline (the 3-stage block class, including multicycle stages) between NUM_REQ requesters.
- Round-robin arbitration drives a registered issue stage.
- A tag FIFO records the grant index of each in-flight transaction, so each pipeline result is routed back to its originating requester.
- Sits between client masters and the shared datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, payload width for request and response.
- MAX_OUTST, 4, maximum issued-but-unreturned transactions; tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_data_i  in  NUM_REQ*DATA_W  request payloads; requester k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero.
- pipe_valid_o  out  1  issue valid to shared pipeline.
- pipe_data_o  out  DATA_W  issued payload.
- pipe_ready_i  in  1  shared pipeline accepts issue.
- pipe_valid_i  in  1  result valid from pipeline.
- pipe_data_i  in  DATA_W  result payload.
- pipe_ready_o  out  1  result accept to pipeline.
- rsp_valid_o  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_data_o  out  DATA_W  response payload, shared by all requesters.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - pipe_valid_o=0, pipe_data_o=0, rr pointer=0, outstanding count=0, tag FIFO empty, err_o=0.
  - All combinational outputs follow from these values.
- Issue stage FSM, states IDLE and HOLD:
  - IDLE: accepts a request when any req_valid_i is set and count_q < MAX_OUTST.
  - HOLD: pipe_valid_o=1. Stays in HOLD until pipe_ready_i; payload and grant stay frozen, with no re-arbitration.
  - HOLD & pipe_ready_i: if a new request is eligible the same cycle, accept it and stay in HOLD (back-to-back issue, one per cycle); otherwise go to IDLE.
  - "Can accept" = (IDLE or pipe_ready_i) and count_q < MAX_OUTST.
- Arbitration:
  - Winner is the first set req_valid_i scanning from the rr pointer upward, with wrap.
  - req_ready_o[winner]=1 only when the stage can accept.
  - On acceptance, the rr pointer moves to winner+1 mod NUM_REQ.
  - The pointer does not move when nothing is accepted.
- Latency: request accepted at edge N gives pipe_valid_o=1 with that payload from cycle N+1.
- Tag FIFO:
  - The winner index is pushed on request acceptance, not on pipe handshake. count_q therefore includes the one held in the issue register.
  - It is popped on a result handshake.
- Full limit:
  - count_q == MAX_OUTST blocks acceptance even if a pop happens the same cycle (registered limit, no bypass).
  - Push and pop in the same cycle leave count_q unchanged.
- Response routing (combinational from FIFO head h):
  - rsp_valid_o[h] = pipe_valid_i & !empty.
  - rsp_data_o = pipe_data_i.
  - pipe_ready_o = rsp_ready_i[h] & !empty.
  - Backpressure from requester h stalls the pipeline; the pipeline's results are in order.
- Empty FIFO with pipe_valid_i=1: spurious result. pipe_ready_o=0 and rsp_valid_o=0.
- rsp_data_o is driven even when no rsp_valid_o is set; consumers qualify with valid.
- Reset mid-transaction drops all in-flight tags. The external pipeline must be reset on the same rst.

Optional Feature:
- Macro: PIPE_ARB_ERR_CHK_EN.
- Defined:
  - err_o is set by a spurious result (pipe_valid_i=1 while the FIFO is empty).
  - err_o is also set when req_data_i of the held winner changes while that requester is still valid but not yet granted; this check is per-requester, AXI-style stability.
  - err_o is sticky until rst.
- Undefined: err_o is tied to 0 and no check logic is synthesized.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all req_valid_i=1 -> pipe_valid_o=0, req_ready_o=0, rsp_valid_o=0, err_o=0; first grant after reset goes to req0.
- Fairness: all four requesters valid, pipe_ready_i=1, pipeline echoes data+1 after 3 cycles -> grant order 0,1,2,3,0,... and each requester receives exactly its own payload+1.
- Backpressure: req2 only, data 0xA5A5_0001, pipe_ready_i=0 for 5 cycles -> pipe_valid_o=1 and pipe_data_o stable for all 5 cycles, no further req_ready_o; issue occurs on the cycle pipe_ready_i rises.
- Outstanding limit: pipeline never returns, all requesters valid -> exactly 4 acceptances, then req_ready_o=0; one result returned -> one further acceptance occurs on the next cycle.
- Response stall: result for req1 with rsp_ready_i[1]=0 for 3 cycles -> rsp_valid_o=0b0010 and pipe_ready_o=0 throughout; the pop happens when rsp_ready_i[1]=1.
- Spurious result with PIPE_ARB_ERR_CHK_EN defined: pipe_valid_i=1 while the FIFO is empty -> pipe_ready_o=0 and err_o=1 the next cycle; err_o stays 1 until rst.
